// File: rtl/tick_gen_pkg.sv
// Shared defaults and helpers for the tick generator and its per-channel counters.
package tick_gen_pkg;

  localparam int unsigned PRESCALE_DFLT = 10;
  localparam int unsigned NUM_CH_DFLT   = 4;
  localparam int unsigned DIV_W_DFLT    = 8;
  localparam int unsigned DEF_DIV_DFLT  = 1;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tick_mode_e;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: divides base ticks by an active divisor, with a pending
// setting that is swapped in at the next reload.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_evt_i,
  input  logic             sync_clr_i,
  input  logic             cfg_we_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_oneshot_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] RST_CNT = (DEF_DIV == 0) ? '0 : DIV_W'(DEF_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ccnt_q, ccnt_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  tick_mode_e       mode_q, mode_d;
  tick_mode_e       pend_mode_q, pend_mode_d;
  logic             pend_valid_q, pend_valid_d;
  logic             tick_q, tick_d;

  // Reload value for a divisor; an idle divisor keeps the counter at zero.
  function automatic logic [DIV_W-1:0] minus1(input logic [DIV_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  always_comb begin
    div_d        = div_q;
    ccnt_d       = ccnt_q;
    mode_d       = mode_q;
    pend_div_d   = pend_div_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;

    if (sync_clr_i) begin
      if (pend_valid_q) begin
        div_d        = pend_div_q;
        mode_d       = pend_mode_q;
        ccnt_d       = minus1(pend_div_q);
        pend_valid_d = 1'b0;
      end else begin
        ccnt_d = minus1(div_q);
      end
    end else if (base_evt_i && (div_q != '0)) begin
      if (ccnt_q == '0) begin
        tick_d = 1'b1;
        if (pend_valid_q) begin
          div_d        = pend_div_q;
          mode_d       = pend_mode_q;
          ccnt_d       = minus1(pend_div_q);
          pend_valid_d = 1'b0;
        end else if (mode_q == MODE_ONESHOT) begin
          div_d  = '0;
          ccnt_d = '0;
        end else begin
          ccnt_d = minus1(div_q);
        end
      end else begin
        ccnt_d = ccnt_q - 1'b1;
      end
    end

    // A write lands on the post-event state: idle channels take it at once,
    // running ones queue it behind the current period.
    if (cfg_we_i) begin
      if (div_d == '0) begin
        div_d        = cfg_div_i;
        mode_d       = tick_mode_e'(cfg_oneshot_i);
        ccnt_d       = minus1(cfg_div_i);
        pend_valid_d = 1'b0;
      end else begin
        pend_div_d   = cfg_div_i;
        pend_mode_d  = tick_mode_e'(cfg_oneshot_i);
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= RST_DIV;
      ccnt_q       <= RST_CNT;
      mode_q       <= MODE_PERIODIC;
      pend_div_q   <= '0;
      pend_mode_q  <= MODE_PERIODIC;
      pend_valid_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      ccnt_q       <= ccnt_d;
      mode_q       <= mode_d;
      pend_div_q   <= pend_div_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      tick_q       <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tick_generator.sv
// Shared prescaler producing base ticks, fanned out to NUM_CH divisor channels.
module tick_generator
  import tick_gen_pkg::*;
#(
  parameter  int unsigned PRESCALE = PRESCALE_DFLT,
  parameter  int unsigned NUM_CH   = NUM_CH_DFLT,
  parameter  int unsigned DIV_W    = DIV_W_DFLT,
  parameter  int unsigned DEF_DIV  = DEF_DIV_DFLT,
  localparam int unsigned CH_W     = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_oneshot,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick
);

  localparam int unsigned    PW        = clog2_min1(PRESCALE);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              base_evt;
  logic              base_tick_q;
  logic [NUM_CH-1:0] ch_we;

  always_comb begin
    presc_d  = presc_q;
    base_evt = 1'b0;
    if (sync_clr) begin
      presc_d = PRESC_MAX;
    end else if (enable) begin
      if (presc_q == '0) begin
        base_evt = 1'b1;
        presc_d  = PRESC_MAX;
      end else begin
        presc_d = presc_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= PRESC_MAX;
      base_tick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      base_tick_q <= base_evt;
    end
  end

  assign base_tick = base_tick_q;

  // Channel numbers beyond NUM_CH match no instance, so such writes are dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    tick_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .base_evt_i    (base_evt),
      .sync_clr_i    (sync_clr),
      .cfg_we_i      (ch_we[gi]),
      .cfg_div_i     (cfg_div),
      .cfg_oneshot_i (cfg_oneshot),
      .tick_o        (tick[gi])
    );
  end

endmodule

// File: tb/tb_tick_generator.sv
// Bench for tick_generator: per-edge vector tables plus reset/async corner sequences.
module tb_tick_generator;

  typedef struct {
    int         edge_n;
    logic       en_off;
    logic       sclr;
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic       os;
    logic       base;
    logic [3:0] tk;
  } vec_t;

  typedef struct {
    int         edge_n;
    logic       base;
    logic [3:0] tk;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       sync_clr = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_oneshot = 1'b0;
  logic       base_tick;
  logic [3:0] tick;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  exp_t sb[$];
  logic [3:0] pat_b [0:10];

  always #5 clk = ~clk;

  tick_generator #(
    .PRESCALE (10),
    .NUM_CH   (4),
    .DIV_W    (8),
    .DEF_DIV  (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sync_clr    (sync_clr),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_oneshot (cfg_oneshot),
    .base_tick   (base_tick),
    .tick        (tick)
  );

  task automatic add_vec(input int e, input logic en_off, input logic sclr, input logic we,
                         input logic [1:0] ch, input logic [7:0] dv, input logic os,
                         input logic b, input logic [3:0] tk);
    vec_t v;
    v.edge_n = e; v.en_off = en_off; v.sclr = sclr; v.we = we;
    v.ch = ch; v.div = dv; v.os = os; v.base = b; v.tk = tk;
    vecs.push_back(v);
  endtask

  task automatic add_exp(input int e, input logic [3:0] tk);
    add_vec(e, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b1, tk);
  endtask

  task automatic add_cfg(input int e, input logic [1:0] ch, input logic [7:0] dv, input logic os);
    add_vec(e, 1'b0, 1'b0, 1'b1, ch, dv, os, 1'b0, 4'h0);
  endtask

  task automatic add_ctl(input int e, input logic en_off, input logic sclr);
    add_vec(e, en_off, sclr, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic set_idle();
    enable = 1'b1; sync_clr = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
  endtask

  // Entered at a negedge; edge 1 is the next rising edge.
  task automatic run_table(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      logic en_off, sclr, we, os, b;
      logic [1:0] ch;
      logic [7:0] dv;
      logic [3:0] tk;
      exp_t x;
      en_off = 1'b0; sclr = 1'b0; we = 1'b0; os = 1'b0; b = 1'b0;
      ch = '0; dv = '0; tk = '0;
      foreach (vecs[i]) begin
        if (vecs[i].edge_n == e) begin
          en_off = en_off | vecs[i].en_off;
          sclr   = sclr | vecs[i].sclr;
          b      = b | vecs[i].base;
          tk     = tk | vecs[i].tk;
          if (vecs[i].we) begin
            we = 1'b1; ch = vecs[i].ch; dv = vecs[i].div; os = vecs[i].os;
          end
          $display("%s e=%0d en_off=%b sclr=%b we=%b ch=%0d div=%0d os=%b exp_base=%b exp_tick=%h",
                   tag, e, vecs[i].en_off, vecs[i].sclr, vecs[i].we, vecs[i].ch,
                   vecs[i].div, vecs[i].os, vecs[i].base, vecs[i].tk);
        end
      end
      enable = ~en_off; sync_clr = sclr; cfg_we = we;
      cfg_ch = ch; cfg_div = dv; cfg_oneshot = os;
      x.edge_n = e; x.base = b; x.tk = tk;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      checks++;
      if (base_tick !== x.base) begin
        errors++;
        $display("FAIL %s base_tick edge=%0d got=%b exp=%b", tag, x.edge_n, base_tick, x.base);
      end
      checks++;
      if (tick !== x.tk) begin
        errors++;
        $display("FAIL %s tick edge=%0d got=%h exp=%h", tag, x.edge_n, tick, x.tk);
      end
      @(negedge clk);
    end
    set_idle();
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    repeat (2) @(negedge clk);
    checks++;
    if (base_tick !== 1'b0 || tick !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got base=%b tick=%h exp base=0 tick=0", base_tick, tick);
    end
    $display("reset released");
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // Default divisor 1 on all channels: every base tick fires every channel.
    for (int k = 1; k <= 3; k++) add_exp(10 * k, 4'hF);
    run_table("A_default", 35);

    // ch0 pending overwritten 5 -> 2, ch1 pending 3; both swap in at edge 20.
    do_reset();
    pat_b = '{4'hF, 4'hF, 4'hC, 4'hD, 4'hE, 4'hD, 4'hC, 4'hF, 4'hC, 4'hD, 4'hE};
    add_cfg(12, 2'd0, 8'd5, 1'b0);
    add_cfg(14, 2'd0, 8'd2, 1'b0);
    add_cfg(16, 2'd1, 8'd3, 1'b0);
    for (int k = 0; k <= 10; k++) add_exp(10 * (k + 1), pat_b[k]);
    run_table("B_pending", 115);

    // ch2 idled via pending 0, then a oneshot of 2 fires once at edge 40.
    do_reset();
    add_cfg(12, 2'd2, 8'd0, 1'b0);
    add_cfg(22, 2'd2, 8'd2, 1'b1);
    for (int k = 1; k <= 25; k++) add_exp(10 * k, (k == 1 || k == 2 || k == 4) ? 4'hF : 4'hB);
    run_table("C_oneshot", 255);

    // Enable gap shifts the phase by 5; write coincident with ch0 expiry.
    do_reset();
    for (int e = 15; e <= 19; e++) add_ctl(e, 1'b1, 1'b0);
    add_cfg(25, 2'd0, 8'd2, 1'b0);
    add_exp(10, 4'hF); add_exp(25, 4'hF); add_exp(35, 4'hF);
    add_exp(45, 4'hE); add_exp(55, 4'hF); add_exp(65, 4'hE);
    run_table("D_enable", 66);

    // sync_clr at edge 8 with coincident write to ch3 (queued as pending).
    do_reset();
    add_ctl(8, 1'b0, 1'b1);
    add_cfg(8, 2'd3, 8'd3, 1'b0);
    add_exp(18, 4'hF); add_exp(28, 4'h7); add_exp(38, 4'h7);
    add_exp(48, 4'hF); add_exp(58, 4'h7);
    run_table("E_syncclr", 58);

    // Asynchronous reset mid-period while outputs are high.
    checks++;
    if (base_tick !== 1'b1) begin
      errors++;
      $display("FAIL pre_async_rst base_tick got=%b exp=1", base_tick);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (base_tick !== 1'b0 || tick !== 4'h0) begin
      errors++;
      $display("FAIL async_rst got base=%b tick=%h exp base=0 tick=0", base_tick, tick);
    end
    $display("async reset asserted mid-period");
    @(negedge clk);
    rst = 1'b1;
    add_exp(10, 4'hF); add_exp(20, 4'hF);
    run_table("E_restart", 22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
